// File: rtl/dmem_port_arbiter_if.sv
// Bus bundle between the data-memory port arbiter, its two requesters
// (load queue, store-commit path) and the fixed-latency memory.
interface dmem_port_arbiter_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int TAG_W  = 6
);
    logic              ld_req_valid;
    logic              ld_req_ready;
    logic [ADDR_W-1:0] ld_req_addr;
    logic [TAG_W-1:0]  ld_req_tag;

    logic              st_req_valid;
    logic              st_req_ready;
    logic [ADDR_W-1:0] st_req_addr;
    logic [DATA_W-1:0] st_req_data;
    logic              st_req_size;

    logic              flush;

    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_read;
    logic              mem_write;
    logic              mem_size;
    logic [DATA_W-1:0] mem_rdata;

    logic              ld_resp_valid;
    logic [TAG_W-1:0]  ld_resp_tag;
    logic [DATA_W-1:0] ld_resp_data;
    logic              st_done;
    logic              busy;

    modport slave (
        input  ld_req_valid, ld_req_addr, ld_req_tag,
        input  st_req_valid, st_req_addr, st_req_data, st_req_size,
        input  flush, mem_rdata,
        output ld_req_ready, st_req_ready,
        output mem_addr, mem_wdata, mem_read, mem_write, mem_size,
        output ld_resp_valid, ld_resp_tag, ld_resp_data, st_done, busy
    );

    modport master (
        output ld_req_valid, ld_req_addr, ld_req_tag,
        output st_req_valid, st_req_addr, st_req_data, st_req_size,
        output flush, mem_rdata,
        input  ld_req_ready, st_req_ready,
        input  mem_addr, mem_wdata, mem_read, mem_write, mem_size,
        input  ld_resp_valid, ld_resp_tag, ld_resp_data, st_done, busy
    );
endinterface

// File: rtl/dmem_port_arbiter.sv
// Single-port data-memory sequencer: arbitrates loads vs stores, holds the
// memory command for the full access latency, then issues one completion.
//
// state    | meaning
// S_IDLE   | arbitrate; ready is asserted combinationally for the winner
// S_ACCESS | command held stable for MEM_LAT+1 cycles (cnt 0..MEM_LAT)
// S_RESP   | one-cycle load response (unless squashed) or store-done pulse
module dmem_port_arbiter #(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    parameter int TAG_W       = 6,
    parameter int MEM_LAT     = 10,
    parameter int ST_MAX_WAIT = 4
) (
    input  logic               clk,
    input  logic               rstn,
    dmem_port_arbiter_if.slave bus
);
    localparam int CW = (MEM_LAT > 0) ? $clog2(MEM_LAT + 1) : 1;
    localparam int SW = (ST_MAX_WAIT > 0) ? $clog2(ST_MAX_WAIT + 1) : 1;
    localparam logic [CW-1:0] LAT_END    = CW'(MEM_LAT);
    localparam logic [SW-1:0] STARVE_MAX = SW'(ST_MAX_WAIT);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_RESP   = 2'd2
    } state_t;

    state_t            r_state;
    logic [CW-1:0]     r_cnt;
    logic [SW-1:0]     r_starve;
    logic              r_squash;
    logic              r_is_st;
    logic [TAG_W-1:0]  r_tag;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic              r_size;
    logic              r_mem_read;
    logic              r_mem_write;
    logic              r_ld_resp_valid;
    logic              r_st_done;
    logic              r_busy;

    logic w_idle;
    logic w_grant_st;
    logic w_grant_ld;
    logic w_st_hs;
    logic w_ld_hs;

    // Store wins only when no load competes or it has lost ST_MAX_WAIT times in a row
    assign w_idle     = (r_state == S_IDLE);
    assign w_grant_st = bus.st_req_valid && (!bus.ld_req_valid || (r_starve == STARVE_MAX));
    assign w_grant_ld = !w_grant_st && bus.ld_req_valid && !bus.flush;
    assign w_st_hs    = rstn && w_idle && w_grant_st;
    assign w_ld_hs    = rstn && w_idle && w_grant_ld;

    assign bus.st_req_ready  = w_st_hs;
    assign bus.ld_req_ready  = w_ld_hs;
    assign bus.mem_addr      = r_addr;
    assign bus.mem_wdata     = r_wdata;
    assign bus.mem_size      = r_size;
    assign bus.mem_read      = r_mem_read;
    assign bus.mem_write     = r_mem_write;
    assign bus.ld_resp_valid = r_ld_resp_valid;
    assign bus.ld_resp_tag   = r_ld_resp_valid ? r_tag : '0;
    assign bus.ld_resp_data  = r_ld_resp_valid ? bus.mem_rdata : '0;
    assign bus.st_done       = r_st_done;
    assign bus.busy          = r_busy;

    // Sequencer: accept one op, hold the command through the latency, then complete
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state         <= S_IDLE;
            r_cnt           <= '0;
            r_starve        <= '0;
            r_squash        <= 1'b0;
            r_is_st         <= 1'b0;
            r_tag           <= '0;
            r_addr          <= '0;
            r_wdata         <= '0;
            r_size          <= 1'b0;
            r_mem_read      <= 1'b0;
            r_mem_write     <= 1'b0;
            r_ld_resp_valid <= 1'b0;
            r_st_done       <= 1'b0;
            r_busy          <= 1'b0;
        end else begin
            r_ld_resp_valid <= 1'b0;
            r_st_done       <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_st_hs) begin
                        r_addr      <= bus.st_req_addr;
                        r_wdata     <= bus.st_req_data;
                        r_size      <= bus.st_req_size;
                        r_is_st     <= 1'b1;
                        r_mem_write <= 1'b1;
                        r_starve    <= '0;
                    end else if (w_ld_hs) begin
                        r_addr     <= bus.ld_req_addr;
                        r_tag      <= bus.ld_req_tag;
                        r_is_st    <= 1'b0;
                        r_mem_read <= 1'b1;
                        if (bus.st_req_valid && (r_starve != STARVE_MAX))
                            r_starve <= r_starve + SW'(1);
                    end
                    if (w_st_hs || w_ld_hs) begin
                        r_state  <= S_ACCESS;
                        r_cnt    <= '0;
                        r_squash <= 1'b0;
                        r_busy   <= 1'b1;
                    end
                end
                S_ACCESS: begin
                    // The access cannot abort; a flush only hides the load's response
                    if (bus.flush && !r_is_st)
                        r_squash <= 1'b1;
                    if (r_cnt == LAT_END) begin
                        r_mem_read      <= 1'b0;
                        r_mem_write     <= 1'b0;
                        r_state         <= S_RESP;
                        r_ld_resp_valid <= !r_is_st && !r_squash && !bus.flush;
                        r_st_done       <= r_is_st;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                S_RESP: begin
                    r_state  <= S_IDLE;
                    r_busy   <= 1'b0;
                    r_squash <= 1'b0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dmem_port_arbiter.sv
// Bench for dmem_port_arbiter: fixed-latency byte memory, shadow memory
// reference and a cycle-indexed expectation per operation.
module tb_dmem_port_arbiter;
    localparam int ADDR_W      = 32;
    localparam int DATA_W      = 32;
    localparam int TAG_W       = 6;
    localparam int MEM_LAT     = 10;
    localparam int ST_MAX_WAIT = 4;

    logic clk;
    logic rstn;
    int   n_checks = 0;
    int   n_errors = 0;

    logic [7:0] mem_b [0:255];
    logic [7:0] ref_b [0:255];
    int         mem_hold = 0;
    logic [7:0] w_a0;
    logic [7:0] w_a1;

    dmem_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W)) bus ();

    dmem_port_arbiter #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .TAG_W(TAG_W),
        .MEM_LAT(MEM_LAT), .ST_MAX_WAIT(ST_MAX_WAIT)
    ) dut (
        .clk (clk),
        .rstn(rstn),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign w_a0 = bus.mem_addr[7:0];
    assign w_a1 = w_a0 + 8'd1;

    // Memory performs the access on the edge closing the (MEM_LAT+1)th held command cycle
    always @(posedge clk) begin
        if (bus.mem_read || bus.mem_write) begin
            if (mem_hold == MEM_LAT) begin
                if (bus.mem_write) begin
                    if (bus.mem_size) begin
                        mem_b[w_a0] <= bus.mem_wdata[7:0];
                    end else begin
                        mem_b[w_a0] <= bus.mem_wdata[15:8];
                        mem_b[w_a1] <= bus.mem_wdata[7:0];
                    end
                end else begin
                    bus.mem_rdata <= {16'h0, mem_b[w_a0], mem_b[w_a1]};
                end
            end
            mem_hold <= mem_hold + 1;
        end else begin
            mem_hold <= 0;
        end
    end

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [7:0] a);
        logic [7:0] a1;
        a1 = a + 8'd1;
        return {16'h0, ref_b[a], ref_b[a1]};
    endfunction

    task automatic ref_store(input logic [7:0] a, input logic [31:0] d, input bit size);
        logic [7:0] a1;
        a1 = a + 8'd1;
        if (size) begin
            ref_b[a] = d[7:0];
        end else begin
            ref_b[a]  = d[15:8];
            ref_b[a1] = d[7:0];
        end
    endtask

    // Present one request and wait for its handshake; waited = idle cycles before ready
    task automatic start_op(input bit is_st, input logic [31:0] addr, input logic [31:0] data,
                            input bit size, input logic [5:0] tag, output int waited);
        @(negedge clk);
        if (is_st) begin
            bus.st_req_valid = 1'b1;
            bus.st_req_addr  = addr;
            bus.st_req_data  = data;
            bus.st_req_size  = size;
        end else begin
            bus.ld_req_valid = 1'b1;
            bus.ld_req_addr  = addr;
            bus.ld_req_tag   = tag;
        end
        #1;
        waited = 0;
        while (!(is_st ? bus.st_req_ready : bus.ld_req_ready) && waited < 40) begin
            @(negedge clk);
            #1;
            waited++;
        end
        check("accept_timeout", waited < 40, 1);
        @(posedge clk);
        #1;
        if (is_st) bus.st_req_valid = 1'b0;
        else       bus.ld_req_valid = 1'b0;
    endtask

    // Cycles 1..12 after the handshake: command window, then the completion cycle
    task automatic watch_op(input bit is_st, input logic [31:0] addr, input logic [31:0] data,
                            input bit size, input logic [5:0] tag, input int flush_at,
                            input int pend_at, input logic [31:0] pend_addr, input logic [5:0] pend_tag);
        logic [31:0] exp_rd;
        bit          exp_resp;
        exp_rd   = ref_load(addr[7:0]);
        exp_resp = !is_st && !(flush_at >= 1 && flush_at <= MEM_LAT + 1);
        for (int k = 1; k <= MEM_LAT + 2; k++) begin
            @(negedge clk);
            bus.flush = (k == flush_at);
            if (k == pend_at) begin
                bus.ld_req_valid = 1'b1;
                bus.ld_req_addr  = pend_addr;
                bus.ld_req_tag   = pend_tag;
            end
            #1;
            check("mem_read",  bus.mem_read,  !is_st && k <= MEM_LAT + 1);
            check("mem_write", bus.mem_write, is_st && k <= MEM_LAT + 1);
            check("busy", bus.busy, 1);
            check("ld_ready_busy", bus.ld_req_ready, 0);
            check("st_ready_busy", bus.st_req_ready, 0);
            if (k <= MEM_LAT + 1) begin
                check("mem_addr", bus.mem_addr, addr);
                if (is_st) begin
                    check("mem_wdata", bus.mem_wdata, data);
                    check("mem_size",  bus.mem_size, size);
                end
            end
            if (k == MEM_LAT + 2) begin
                check("ld_resp_valid", bus.ld_resp_valid, exp_resp);
                check("st_done", bus.st_done, is_st);
                if (exp_resp) begin
                    check("ld_resp_tag",  bus.ld_resp_tag, tag);
                    check("ld_resp_data", bus.ld_resp_data, exp_rd);
                end
            end else begin
                check("ld_resp_early", bus.ld_resp_valid, 0);
                check("st_done_early", bus.st_done, 0);
            end
        end
        bus.flush = 1'b0;
        if (is_st) ref_store(addr[7:0], data, size);
    endtask

    task automatic run_op(input bit is_st, input logic [31:0] addr, input logic [31:0] data,
                          input bit size, input logic [5:0] tag, input int flush_at);
        int waited;
        start_op(is_st, addr, data, size, tag, waited);
        watch_op(is_st, addr, data, size, tag, flush_at, 0, 32'h0, 6'h0);
    endtask

    // Both requesters held valid: grants follow the starvation rule, one per 13 cycles
    task automatic contention_test();
        int         cyc = 0;
        int         last = 0;
        int         starve = 0;
        int         waited;
        bit         exp_st;
        logic [9:0] order;
        order = '0;
        @(negedge clk);
        bus.ld_req_valid = 1'b1;
        bus.ld_req_addr  = 32'hC4;
        bus.ld_req_tag   = 6'd11;
        bus.st_req_valid = 1'b1;
        bus.st_req_addr  = 32'hC0;
        bus.st_req_data  = 32'h0000_1357;
        bus.st_req_size  = 1'b0;
        for (int g = 0; g < 10; g++) begin
            waited = 0;
            #1;
            while (!(bus.ld_req_ready || bus.st_req_ready) && waited < 30) begin
                @(negedge clk);
                cyc++;
                #1;
                waited++;
            end
            check("cont_timeout", waited < 30, 1);
            exp_st = (starve == ST_MAX_WAIT);
            check("cont_st_grant", bus.st_req_ready, exp_st);
            check("cont_ld_grant", bus.ld_req_ready, !exp_st);
            order[g] = bus.st_req_ready;
            if (g > 0) check("cont_spacing", cyc - last, MEM_LAT + 3);
            last = cyc;
            if (bus.st_req_ready) starve = 0;
            else if (starve < ST_MAX_WAIT) starve++;
            if (g == 9) begin
                @(posedge clk);
                #1;
                bus.ld_req_valid = 1'b0;
                bus.st_req_valid = 1'b0;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        check("cont_order", order, 10'b10_0001_0000);
        repeat (MEM_LAT + 3) @(negedge clk);
        ref_store(8'hC0, 32'h0000_1357, 1'b0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          waited;
        bit          is_st;
        logic [31:0] addr;
        logic [31:0] data;
        bit          size;
        logic [5:0]  tag;
        int          fl;
        logic [7:0]  v;

        for (int i = 0; i < 256; i++) begin
            v = 8'($urandom);
            mem_b[i] <= v;
            ref_b[i] = v;
        end
        mem_b[8'h40] <= 8'h12; ref_b[8'h40] = 8'h12;
        mem_b[8'h41] <= 8'h34; ref_b[8'h41] = 8'h34;

        rstn = 1'b0;
        bus.ld_req_valid = 1'b0; bus.ld_req_addr = '0; bus.ld_req_tag = '0;
        bus.st_req_valid = 1'b0; bus.st_req_addr = '0; bus.st_req_data = '0;
        bus.st_req_size  = 1'b0; bus.flush = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_ld_ready", bus.ld_req_ready, 0);
        check("rst_st_ready", bus.st_req_ready, 0);
        check("rst_mem_read", bus.mem_read, 0);
        check("rst_mem_write", bus.mem_write, 0);
        check("rst_mem_addr", bus.mem_addr, 0);
        check("rst_mem_wdata", bus.mem_wdata, 0);
        check("rst_mem_size", bus.mem_size, 0);
        check("rst_ld_resp_valid", bus.ld_resp_valid, 0);
        check("rst_ld_resp_tag", bus.ld_resp_tag, 0);
        check("rst_ld_resp_data", bus.ld_resp_data, 0);
        check("rst_st_done", bus.st_done, 0);
        check("rst_busy", bus.busy, 0);
        rstn = 1'b1;

        // Load 0x40 tag 5 returns the preloaded halfword
        start_op(1'b0, 32'h40, 32'h0, 1'b0, 6'd5, waited);
        check("ld40_wait", waited, 0);
        check("ld40_ref", ref_load(8'h40), 32'h0000_1234);
        watch_op(1'b0, 32'h40, 32'h0, 1'b0, 6'd5, 0, 0, 32'h0, 6'h0);

        // Store halfword then read it back
        run_op(1'b1, 32'h80, 32'h0000_ABCD, 1'b0, 6'd0, 0);
        run_op(1'b0, 32'h80, 32'h0, 1'b0, 6'd9, 0);

        // Flush during cycle 5 of a load: access completes, response hidden
        run_op(1'b0, 32'h40, 32'h0, 1'b0, 6'd3, 5);
        @(negedge clk);
        #1;
        check("flush_busy_drop", bus.busy, 0);

        // Flush in IDLE blocks the load grant for that cycle only
        @(negedge clk);
        bus.ld_req_valid = 1'b1; bus.ld_req_addr = 32'h10; bus.ld_req_tag = 6'd7;
        bus.flush = 1'b1;
        #1;
        check("flush_idle_block", bus.ld_req_ready, 0);
        @(negedge clk);
        bus.flush = 1'b0;
        #1;
        check("flush_idle_release", bus.ld_req_ready, 1);
        @(posedge clk);
        #1;
        bus.ld_req_valid = 1'b0;
        watch_op(1'b0, 32'h10, 32'h0, 1'b0, 6'd7, 0, 0, 32'h0, 6'h0);

        // Load requested during ACCESS is accepted at T+13
        start_op(1'b0, 32'h20, 32'h0, 1'b0, 6'd1, waited);
        watch_op(1'b0, 32'h20, 32'h0, 1'b0, 6'd1, 0, 3, 32'h22, 6'd2);
        start_op(1'b0, 32'h22, 32'h0, 1'b0, 6'd2, waited);
        check("pend_accept_t13", waited, 0);
        watch_op(1'b0, 32'h22, 32'h0, 1'b0, 6'd2, 0, 0, 32'h0, 6'h0);

        // Reset in cycle 6 of a store: command drops at once, no completion, no write
        start_op(1'b1, 32'h90, 32'h0000_5A5A, 1'b0, 6'd0, waited);
        repeat (6) @(negedge clk);
        #1;
        check("rstmid_write_before", bus.mem_write, 1);
        rstn = 1'b0;
        #1;
        check("rstmid_write", bus.mem_write, 0);
        check("rstmid_busy", bus.busy, 0);
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            #1;
            check("rstmid_st_done", bus.st_done, 0);
        end
        @(posedge clk);
        #1;
        rstn = 1'b1;
        start_op(1'b0, 32'h90, 32'h0, 1'b0, 6'd4, waited);
        check("rstmid_accept", waited, 0);
        watch_op(1'b0, 32'h90, 32'h0, 1'b0, 6'd4, 0, 0, 32'h0, 6'h0);

        contention_test();

        // Randomized single operations against the shadow memory
        for (int i = 0; i < 24; i++) begin
            is_st = 1'($urandom_range(0, 1));
            addr  = $urandom;
            data  = $urandom;
            size  = 1'($urandom_range(0, 1));
            tag   = 6'($urandom);
            fl    = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, MEM_LAT + 1)) : 0;
            run_op(is_st, addr, data, size, tag, fl);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/dmem_port_arbiter.md
# dmem_port_arbiter

Sequencing controller and two-requester arbiter for the single-port, fixed-latency data memory. It accepts load requests from the load queue and store requests from the store-commit path, and grants the memory port to one operation at a time. It holds the memory command stable for the full access latency and returns load data tagged for the ROB/CDB, or a store-done pulse. A starvation guard keeps stores from being locked out by load traffic, and a flush input squashes an in-flight load response.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TAG_W, 6, load tag (ROB index) width
- MEM_LAT, 10, memory wait cycles before the access is performed
- ST_MAX_WAIT, 4, consecutive lost arbitrations after which a waiting store wins
- clk  in  1  clock, all state on rising edge
- rstn  in  1  reset, asynchronous, active-low
- ld_req_valid  in  1  load request
- ld_req_ready  out  1  load accepted this cycle when high with valid
- ld_req_addr  in  ADDR_W  load byte address
- ld_req_tag  in  TAG_W  load tag
- st_req_valid  in  1  store request
- st_req_ready  out  1  store accepted this cycle when high with valid
- st_req_addr  in  ADDR_W  store byte address
- st_req_data  in  DATA_W  store data
- st_req_size  in  1  0 = 16-bit word (data[15:0]), 1 = byte (data[7:0])
- flush  in  1  squash pending/in-flight loads
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_read  out  1  memory read command
- mem_write  out  1  memory write command
- mem_size  out  1  store size to memory
- mem_rdata  in  DATA_W  memory read data, valid the cycle after the access edge
- ld_resp_valid  out  1  one-cycle load completion
- ld_resp_tag  out  TAG_W  tag of completing load
- ld_resp_data  out  DATA_W  load data (mem_rdata pass-through)
- st_done  out  1  one-cycle store completion
- busy  out  1  state != IDLE

## Operation
- States: IDLE, ACCESS, RESP.
- IDLE: arbitrate. Grant store if st_req_valid and (not ld_req_valid, or starve_cnt == ST_MAX_WAIT); otherwise grant load if ld_req_valid and not flush. Otherwise no grant.
- ready outputs are combinational: high only in IDLE for the granted requester. Ready is never high in ACCESS or RESP.
- On handshake: latch addr, data, size, tag, and op type; go to ACCESS with cnt = 0.
- starve_cnt: increments (saturating at ST_MAX_WAIT) when a load is granted while st_req_valid = 1. Clears on store grant.
- ACCESS: mem_read or mem_write is held at 1 and mem_addr, mem_wdata, and mem_size are held stable from latched values. cnt increments each cycle. At cnt == MEM_LAT, the command is still asserted that cycle; go to RESP next.
- RESP: command deasserted. For a load, ld_resp_valid = 1 unless the load was squashed, with latched tag and ld_resp_data = mem_rdata. For a store, st_done = 1. Then go to IDLE.
- Flush: sets a squash flag on an in-flight load. The memory access still runs to completion (it cannot abort), and only ld_resp_valid is suppressed. flush in IDLE blocks load grant that cycle. flush has no effect on stores.
- Outside ACCESS, mem_read = mem_write = 0. mem_addr and mem_wdata hold their last value.

## Timing
- Reset (async assert): state IDLE, cnt 0, starve_cnt 0, squash 0. All outputs 0: ready, mem_read, mem_write, mem_addr, mem_wdata, mem_size, ld_resp_*, st_done, busy.
- Handshake in cycle T: ACCESS occupies T+1 .. T+1+MEM_LAT (MEM_LAT+1 cycles). RESP is at T+MEM_LAT+2. Next accept is possible at T+MEM_LAT+3.
- With MEM_LAT = 10, this gives a 12-cycle request-to-response latency and one operation per 13 cycles.
- Reset mid-ACCESS: immediate return to IDLE with the command dropped. No response is issued.
- Simultaneous valid requests with starve_cnt < ST_MAX_WAIT: the load wins.

## Test plan
- Load at 0x40, tag 5, MEM_LAT=10, accepted cycle 0:
  - mem_read high cycles 1–11 with addr 0x40.
  - Cycle 12: ld_resp_valid=1, tag 5, data = mem_rdata (memory preloaded 0x12,0x34 → 0x00001234).
- Store 0xABCD, size 0, to 0x80:
  - mem_write high 11 cycles with wdata 0xABCD and size 0.
  - st_done pulse at cycle 12.
  - A following load of 0x80 returns 0x0000ABCD.
- Load and store valid continuously, ST_MAX_WAIT=4:
  - Grant order L,L,L,L,S,L,L,L,L,S.
  - starve_cnt clears after each S.
- flush asserted in cycle 5 of a load access:
  - mem_read still high through cycle 11.
  - No ld_resp_valid in cycle 12.
  - busy drops in cycle 13.
- rstn pulled low in cycle 6 of a store access:
  - mem_write=0 and busy=0 immediately (asynchronously).
  - No st_done.
  - A new request is accepted on the first cycle after reset release.
- ld_req_valid asserted during ACCESS:
  - ld_req_ready stays 0 until IDLE.
  - Request accepted at T+13.
